// File: rtl/sound_envelope.sv
// Audio loudness envelope: removes ADC DC bias, rectifies, window-averages into a
// level, tracks a decaying peak, and drives a hysteretic loud flag plus LED bar.
module sound_envelope #(
   parameter int WIN_LOG2  = 6,
   parameter int DC_SHIFT  = 8,
   parameter int DECAY_DIV = 16,
   parameter int THRESH_HI = 300,
   parameter int THRESH_LO = 200,
   parameter int LED_STEP  = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_valid,
   input  logic [9:0] sample,
   output logic [9:0] level,
   output logic       level_valid,
   output logic [9:0] peak,
   output logic       loud,
   output logic [7:0] led
);

   // Input is valid-only: sample is consumed in every cycle sample_valid is high,
   // there is no ready and no backpressure; downstream strobes are one-cycle pulses.

   localparam int AW = 10 + DC_SHIFT + 1;
   localparam int SW = 10 + WIN_LOG2;
   localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [AW-1:0] ACC_INIT = AW'(512) << DC_SHIFT;
   localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_DIV - 1);
   localparam logic [13:0] HI14 = 14'(THRESH_HI);
   localparam logic [13:0] LO14 = 14'(THRESH_LO);

   logic [AW-1:0]       acc;
   logic [9:0]          dc;
   logic [9:0]          samp1, dc1, dev2;
   logic                v1, v2;
   logic signed [10:0]  diff;
   logic [10:0]         mag;
   logic [SW-1:0]       sum, sum_next;
   logic [WIN_LOG2-1:0] count;
   logic [DW-1:0]       dcnt;

   // acc always holds at least dc<<DC_SHIFT, so the upper bit above dc is zero
   assign dc = acc[DC_SHIFT+9:DC_SHIFT];

   always_comb begin
      diff     = $signed({1'b0, samp1}) - $signed({1'b0, dc1});
      mag      = diff[10] ? (11'd0 - 11'(diff)) : 11'(diff);
      sum_next = sum + SW'(dev2);
   end

   // Stages 0 and 1: DC tracking and rectification
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= ACC_INIT;
         samp1 <= '0;
         dc1   <= '0;
         v1    <= 1'b0;
         dev2  <= '0;
         v2    <= 1'b0;
      end else begin
         v1   <= sample_valid;
         v2   <= v1;
         dev2 <= mag[9:0];
         if (sample_valid) begin
            samp1 <= sample;
            dc1   <= dc;
            acc   <= acc + AW'(sample) - AW'(dc);
         end
      end
   end

   // Stage 2: window accumulation and peak tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         sum         <= '0;
         count       <= '0;
         level       <= '0;
         level_valid <= 1'b0;
         peak        <= '0;
         dcnt        <= '0;
      end else begin
         level_valid <= 1'b0;
         if (v2) begin
            count <= count + 1'b1;
            if (&count) begin
               level       <= sum_next[SW-1:WIN_LOG2];
               level_valid <= 1'b1;
               sum         <= '0;
            end else begin
               sum <= sum_next;
            end
            if (dev2 > peak) begin
               peak <= dev2;
               dcnt <= '0;
            end else if (dcnt == DECAY_LAST) begin
               dcnt <= '0;
               peak <= (peak != 10'd0) ? peak - 10'd1 : 10'd0;
            end else begin
               dcnt <= dcnt + 1'b1;
            end
         end
      end
   end

   // Stage 3: loud flag with hysteresis and LED thermometer from the fresh level
   always_ff @(posedge clk) begin
      if (rst) begin
         loud <= 1'b0;
         led  <= '0;
      end else if (level_valid) begin
         if ({4'd0, level} >= HI14)
            loud <= 1'b1;
         else if ({4'd0, level} < LO14)
            loud <= 1'b0;
         for (int i = 0; i < 8; i++)
            led[i] <= ({4'd0, level} >= 14'(LED_STEP * (i + 1)));
      end
   end

endmodule

// File: tb/tb_sound_envelope.sv
// Directed bench for sound_envelope: window levels, hysteresis, LED bar, peak
// decay, latency under full and sparse throughput, and mid-window reset.
module tb_sound_envelope;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_valid;
   logic [9:0] sample;
   logic [9:0] level;
   logic       level_valid;
   logic [9:0] peak;
   logic       loud;
   logic [7:0] led;

   sound_envelope dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
      .level(level), .level_valid(level_valid), .peak(peak), .loud(loud), .led(led)
   );

   // clock / reset
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard: captured window results
   logic [9:0] lvl_q[$];
   logic [9:0] pk_q[$];
   int         lvc_q[$];
   logic [8:0] snap_q[$];
   logic       lv_prev = 1'b0;

   always @(negedge clk) begin
      if (lv_prev) snap_q.push_back({loud, led});
      lv_prev = level_valid;
      if (level_valid) begin
         lvl_q.push_back(level);
         pk_q.push_back(peak);
         lvc_q.push_back(cyc);
      end
   end

   int n_cmp = 0;
   int n_bad = 0;
   int last_strobe = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input logic [31:0] act, input int lo, input int hi);
      n_cmp++;
      if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // driver tasks
   task automatic send(input logic [9:0] s);
      @(negedge clk);
      sample_valid = 1'b1;
      sample       = s;
      last_strobe  = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         sample_valid = 1'b0;
      end
   endtask

   task automatic clear_sb();
      lvl_q.delete();
      pk_q.delete();
      lvc_q.delete();
      snap_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      sample_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      clear_sb();
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, " level"}, level, 0);
      check({tag, " level_valid"}, level_valid, 0);
      check({tag, " peak"}, peak, 0);
      check({tag, " loud"}, loud, 0);
      check({tag, " led"}, led, 0);
   endtask

   typedef struct {
      logic [9:0] hi;
      logic [9:0] lo;
      logic [9:0] lvl;
      logic       loud;
      logic [7:0] led;
   } row_t;

   row_t       tbl[7];
   logic [8:0] snap;
   int         s_cyc;
   logic [9:0] first_lvl;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // First-window DC is 512 then oscillates 511/513, hence 400 then 401.
      tbl[0] = '{10'd912, 10'd112, 10'd400, 1'b1, 8'h3F};
      tbl[1] = '{10'd912, 10'd112, 10'd401, 1'b1, 8'h3F};
      tbl[2] = '{10'd912, 10'd112, 10'd401, 1'b1, 8'h3F};
      tbl[3] = '{10'd762, 10'd262, 10'd250, 1'b1, 8'h07};
      tbl[4] = '{10'd762, 10'd262, 10'd250, 1'b1, 8'h07};
      tbl[5] = '{10'd662, 10'd362, 10'd150, 1'b0, 8'h03};
      tbl[6] = '{10'd662, 10'd362, 10'd150, 1'b0, 8'h03};

      rst = 1'b1;
      sample_valid = 1'b0;
      sample = 10'd0;
      repeat (2) @(negedge clk);
      do_reset();
      check_zero_outputs("reset");

      // constant midscale: zero deviation
      for (int i = 0; i < 64; i++) send(10'd512);
      idle(8);
      check("t1 windows", lvl_q.size(), 1);
      if (lvl_q.size() > 0) check("t1 level", lvl_q[0], 0);
      check("t1 peak", peak, 0);
      check("t1 snaps", snap_q.size(), 1);
      if (snap_q.size() > 0) begin
         snap = snap_q[0];
         check("t1 loud", snap[8], 0);
         check("t1 led", snap[7:0], 8'h00);
      end

      // alternating +-100: dc stays 512, level exactly 100
      do_reset();
      for (int i = 0; i < 640; i++) send((i % 2 == 0) ? 10'd612 : 10'd412);
      idle(8);
      check("t2 windows", lvl_q.size(), 10);
      for (int w = 0; w < 10 && w < lvl_q.size() && w < snap_q.size(); w++) begin
         check("t2 level", lvl_q[w], 100);
         check_range("t2 peak", pk_q[w], 99, 101);
         snap = snap_q[w];
         check("t2 led", snap[7:0], 8'h01);
         check("t2 loud", snap[8], 0);
      end

      // table-driven square waves: hysteresis and LED bar
      do_reset();
      for (int r = 0; r < 7; r++)
         repeat (32) begin
            send(tbl[r].hi);
            send(tbl[r].lo);
         end
      idle(8);
      check("t3 windows", lvl_q.size(), 7);
      check("t3 snaps", snap_q.size(), 7);
      for (int r = 0; r < 7 && r < lvl_q.size() && r < snap_q.size(); r++) begin
         snap = snap_q[r];
         check($sformatf("t3 level w%0d", r), lvl_q[r], tbl[r].lvl);
         check($sformatf("t3 loud w%0d", r), snap[8], tbl[r].loud);
         check($sformatf("t3 led w%0d", r), snap[7:0], tbl[r].led);
      end

      // single spike: peak 511 two edges after acceptance, then -1 per 16 samples
      do_reset();
      for (int i = 0; i < 10; i++) send(10'd512);
      send(10'd1023);
      for (int j = 1; j <= 40; j++) begin
         send(10'd512);
         check($sformatf("t4 peak j%0d", j), peak, (j < 3) ? 0 : 511 - (j - 3) / 16);
      end
      idle(4);

      // latency with back-to-back strobes
      do_reset();
      for (int i = 0; i < 64; i++) send((i % 2 == 0) ? 10'd612 : 10'd412);
      s_cyc = last_strobe;
      idle(8);
      first_lvl = 10'd0;
      check("t5 windows", lvl_q.size(), 1);
      if (lvl_q.size() > 0) begin
         first_lvl = lvl_q[0];
         check("t5 latency", lvc_q[0] - s_cyc, 3);
         check("t5 level", lvl_q[0], 100);
      end

      // same data with a strobe every 5th cycle
      do_reset();
      for (int i = 0; i < 64; i++) begin
         send((i % 2 == 0) ? 10'd612 : 10'd412);
         s_cyc = last_strobe;
         idle(4);
      end
      idle(4);
      check("t5s windows", lvl_q.size(), 1);
      if (lvl_q.size() > 0) begin
         check("t5s latency", lvc_q[0] - s_cyc, 3);
         check("t5s level same", lvl_q[0], first_lvl);
      end

      // reset mid-window with a sample in flight
      do_reset();
      for (int i = 0; i < 64 + 30; i++) send((i % 2 == 0) ? 10'd912 : 10'd112);
      @(negedge clk);
      rst = 1'b1;
      sample_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_zero_outputs("t6 after rst");
      clear_sb();
      for (int i = 0; i < 63; i++) send((i % 2 == 0) ? 10'd912 : 10'd112);
      idle(8);
      check("t6 no early window", lvl_q.size(), 0);
      send(10'd112);
      idle(8);
      check("t6 windows", lvl_q.size(), 1);
      if (lvl_q.size() > 0) check("t6 level", lvl_q[0], 400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sound_envelope.md
Name: sound_envelope

Overview:
- Downstream of the single-channel ADC capture stage; consumes its 10-bit audio samples, each qualified by a one-cycle valid strobe.
- Removes the DC bias with a running-mean estimator and rectifies each sample to a deviation magnitude.
- Averages the deviation over fixed windows into a loudness level, and tracks a decaying peak.
- Drives a hysteretic "loud" flag and an 8-LED bar graph for the sound board.

Parameters:
- WIN_LOG2, 6, window length is 2^WIN_LOG2 accepted samples (legal range 1..10).
- DC_SHIFT, 8, DC estimator time constant is 2^DC_SHIFT samples (legal range 2..12).
- DECAY_DIV, 16, number of accepted samples per 1-LSB peak decay step (legal range ≥1).
- THRESH_HI, 300, level at or above this value sets loud.
- THRESH_LO, 200, level below this value clears loud (THRESH_LO ≤ THRESH_HI).
- LED_STEP, 64, level increment per lit LED.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sample_valid  in  1  one-cycle strobe; sample is valid in this cycle.
- sample  in  10  unsigned ADC code, midscale 512.
- level  out  10  windowed mean of |sample - dc|.
- level_valid  out  1  one-cycle pulse in the cycle level updates.
- peak  out  10  decaying peak deviation.
- loud  out  1  hysteretic threshold flag.
- led  out  8  thermometer bar of level.

Behaviour:
- Reset values:
  - level=0, level_valid=0, peak=0, loud=0, led=0.
  - DC accumulator = 512<<DC_SHIFT, so dc=512.
  - Window sum=0, window count=0, decay counter=0, pipeline valids=0.
- Stage 0, at edge E0 with sample_valid=1:
  - samp1<=sample; dc1<=dc; v1<=1.
  - acc<=acc+sample-dc, where dc=acc>>DC_SHIFT.
  - acc width is 10+DC_SHIFT+1 bits, unsigned. It never underflows because acc ≥ dc<<DC_SHIFT.
- Stage 1, at E1 (edge after E0):
  - dev2<=|samp1-dc1|, computed as an 11-bit signed difference, then abs. Result fits 10 bits.
  - v2<=v1.
- Stage 2, at E2 when v2=1:
  - Accumulate sum<=sum+dev2. sum width is 10+WIN_LOG2 bits, with no overflow.
  - count<=count+1. count wraps at 2^WIN_LOG2.
  - When count=2^WIN_LOG2-1:
    - level<=(sum+dev2)>>WIN_LOG2 (truncate).
    - level_valid=1 for exactly one cycle, the cycle after E2.
    - sum<=0.
- Peak update, at E2 when v2=1:
  - If dev2>peak: peak<=dev2 and the decay counter clears.
  - Otherwise the decay counter increments. When it reaches DECAY_DIV-1 it wraps to 0 and peak<=peak-1, saturating at 0.
- loud and led update one cycle after level_valid, from the new level:
  - loud sets if level≥THRESH_HI.
  - loud clears if level<THRESH_LO.
  - loud holds otherwise.
  - led[i]=1 iff level ≥ LED_STEP*(i+1), for i=0..7. Compare at 14-bit width.
- Throughput: sample_valid may assert on every cycle; full throughput is sustained with no backpressure.
- Gaps: the pipeline advances on clk regardless of valid; stages only act on their own valid bits.
- Latency: last sample of window at E0 → level_valid high in the cycle after E2 (3 cycles) → loud/led change 1 cycle later.
- sample_valid low: no state changes except pipeline drain.
- rst takes priority over everything, including mid-window and mid-pipeline:
  - All state returns to reset values.
  - An in-flight sample is discarded; the first sample after reset starts a new window at count 0.
- Outputs are registered only, with no combinational path from inputs.

Test Plan:
- Reset, then 64 samples of constant 512 (WIN_LOG2=6) → level_valid pulses once with level=0; peak=0, loud=0, led=8'h00.
- Reset, then alternating 612/412 for 640 samples → after each window from the 2nd onward, level within 99..101 and peak within 99..101; led=8'h01.
- Square ±400 about 512 for 3 windows, then ±250 for 2 windows, then ±150 for 2 windows:
  - loud=1 after the first window (level≈400).
  - loud stays 1 at level≈250 (hysteresis).
  - loud clears after level≈150.
  - led shows 6, then 3, then 2 LEDs lit.
- Single spike 1023 among 512 samples (DECAY_DIV=16) → peak jumps to ≈511 two cycles after the strobe, then decreases by 1 every 16 samples.
- Back-to-back sample_valid every cycle for 64 samples → level_valid exactly 3 cycles after the 64th strobe; repeat with valid every 5th cycle → identical level.
- Assert rst for 1 cycle after 30 samples of a window → all outputs 0; the next level_valid occurs only after 64 further samples.
